// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the countdown timer: FSM state
//               encoding, BCD digit limits and the zero-digit value.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Largest value of a units digit (sec_ones, keypad digit)
    localparam logic [3:0] C_ONES_MAX   = 4'd9;
    // Largest value of the tens-of-seconds digit
    localparam logic [3:0] C_TENS_MAX   = 4'd5;
    localparam logic [3:0] C_DIGIT_ZERO = 4'd0;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/bcd_digit_down.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_down
// Description : Combinational single-digit BCD down-counter stage. When the
//               decrement enable is high the digit drops by one; a digit at 0
//               wraps to DIGIT_MAX and raises borrow for the next stage.
// Ports       : digit_i  [3:0] current digit
//               dec_i          decrement enable
//               digit_o  [3:0] digit after optional decrement
//               borrow_o       high when the decrement wrapped from 0
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [3:0] DIGIT_MAX = 4'd9
) (
    input  logic [3:0] digit_i,
    input  logic       dec_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (dec_i) begin
            if (digit_i == C_DIGIT_ZERO) begin
                digit_o  = DIGIT_MAX;
                borrow_o = 1'b1;
            end else begin
                digit_o  = digit_i - 4'd1;
            end
        end
    end

endmodule : bcd_digit_down
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Kitchen-style M:SS countdown timer. Digits are entered from a
//               keypad (shift-left entry), then counted down once per
//               tick_1hz_i while running. A one-cycle done pulse marks 0:00.
// Ports       : clk, rst           clock, synchronous active-high reset
//               tick_1hz_i         one-cycle 1 Hz enable
//               key_valid_i        keypad strobe, key_digit_i [3:0] BCD digit
//               start_i/stop_i/clear_i  level-sampled controls
//               door_open_i        (DOOR_INTERLOCK_EN only) door interlock
//               min_o/sec_tens_o/sec_ones_o [3:0] BCD time digits
//               running_o, zero_o, done_pulse_o  status
// Config      : DOOR_INTERLOCK_EN - adds door_open_i; an open door pauses a
//               running count and blocks start.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_digit_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       clear_i,
`ifdef DOOR_INTERLOCK_EN
    input  logic       door_open_i,
`endif
    output logic [3:0] min_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       running_o,
    output logic       zero_o,
    output logic       done_pulse_o
);

    localparam logic [3:0] C_MIN_MAX = 4'(MAX_MIN);

    state_e     state_q;
    logic [3:0] min_q;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic       done_q;

    logic [3:0] w_ones_dec;
    logic [3:0] w_tens_dec;
    logic [3:0] w_min_dec;
    logic       w_ones_borrow;
    logic       w_tens_borrow;
    logic       w_min_borrow;
    logic       w_zero;
    logic       w_dec_zero;
    logic       w_key_ok;
    logic       w_door;
    logic       w_start_ok;

    // Borrow chain: the ones stage always computes "time minus one second";
    // the FSM decides whether to commit it.
    bcd_digit_down #(.DIGIT_MAX(C_ONES_MAX)) u_ones (
        .digit_i  (ones_q),
        .dec_i    (1'b1),
        .digit_o  (w_ones_dec),
        .borrow_o (w_ones_borrow)
    );

    bcd_digit_down #(.DIGIT_MAX(C_TENS_MAX)) u_tens (
        .digit_i  (tens_q),
        .dec_i    (w_ones_borrow),
        .digit_o  (w_tens_dec),
        .borrow_o (w_tens_borrow)
    );

    bcd_digit_down #(.DIGIT_MAX(C_MIN_MAX)) u_min (
        .digit_i  (min_q),
        .dec_i    (w_tens_borrow),
        .digit_o  (w_min_dec),
        .borrow_o (w_min_borrow)
    );

`ifdef DOOR_INTERLOCK_EN
    assign w_door = door_open_i;
`else
    assign w_door = 1'b0;
`endif

    assign w_zero     = (min_q == C_DIGIT_ZERO) && (tens_q == C_DIGIT_ZERO) &&
                        (ones_q == C_DIGIT_ZERO);
    assign w_dec_zero = (w_min_dec == C_DIGIT_ZERO) && (w_tens_dec == C_DIGIT_ZERO) &&
                        (w_ones_dec == C_DIGIT_ZERO);

    // A key is accepted only if every digit stays in range after the shift:
    // current ones becomes tens, current tens becomes minutes.
    assign w_key_ok   = (key_digit_i <= C_ONES_MAX) && (ones_q <= C_TENS_MAX) &&
                        (tens_q <= C_MIN_MAX);

    assign w_start_ok = start_i && !w_zero && !w_door &&
                        ((state_q == ST_IDLE) || (state_q == ST_PAUSED));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            min_q   <= C_DIGIT_ZERO;
            tens_q  <= C_DIGIT_ZERO;
            ones_q  <= C_DIGIT_ZERO;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear_i) begin
                state_q <= ST_IDLE;
                min_q   <= C_DIGIT_ZERO;
                tens_q  <= C_DIGIT_ZERO;
                ones_q  <= C_DIGIT_ZERO;
            end else if (w_door && (state_q == ST_RUNNING)) begin
                state_q <= ST_PAUSED;
            end else if (stop_i && (state_q == ST_RUNNING)) begin
                // Any tick in this cycle is dropped, not deferred.
                state_q <= ST_PAUSED;
            end else if (w_start_ok) begin
                state_q <= ST_RUNNING;
            end else if (tick_1hz_i && (state_q == ST_RUNNING) && !w_min_borrow) begin
                // The minute borrow can only fire when decrementing 0:00,
                // which never happens while running; it guards against wrap.
                min_q  <= w_min_dec;
                tens_q <= w_tens_dec;
                ones_q <= w_ones_dec;
                if (w_dec_zero) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
            end else if (key_valid_i && (state_q == ST_IDLE) && w_key_ok) begin
                min_q  <= tens_q;
                tens_q <= ones_q;
                ones_q <= key_digit_i;
            end
        end
    end

    assign min_o        = min_q;
    assign sec_tens_o   = tens_q;
    assign sec_ones_o   = ones_q;
    assign running_o    = (state_q == ST_RUNNING);
    assign zero_o       = w_zero;
    assign done_pulse_o = done_q;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer. A table of per-cycle
//               input/expected-output records covers keypad entry, counting,
//               borrows, done, pause, clear and reset; hand sequences cover a
//               full 1:05 countdown against a seconds model and the optional
//               door interlock (DOOR_INTERLOCK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       clear;
`ifdef DOOR_INTERLOCK_EN
    logic       door_open;
`endif
    logic [3:0] min_w;
    logic [3:0] tens_w;
    logic [3:0] ones_w;
    logic       running_w;
    logic       zero_w;
    logic       done_w;

    always #5 clk = ~clk;

    countdown_timer #(.MAX_MIN(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz_i   (tick_1hz),
        .key_valid_i  (key_valid),
        .key_digit_i  (key_digit),
        .start_i      (start),
        .stop_i       (stop),
        .clear_i      (clear),
`ifdef DOOR_INTERLOCK_EN
        .door_open_i  (door_open),
`endif
        .min_o        (min_w),
        .sec_tens_o   (tens_w),
        .sec_ones_o   (ones_w),
        .running_o    (running_w),
        .zero_o       (zero_w),
        .done_pulse_o (done_w)
    );

    typedef struct {
        logic       rst;
        logic       tick;
        logic       kv;
        logic [3:0] kd;
        logic       st;
        logic       sp;
        logic       cl;
        logic [3:0] em;
        logic [3:0] et;
        logic [3:0] eo;
        logic       er;
        logic       ez;
        logic       ed;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic t, input logic kv, input logic [3:0] kd,
                       input logic st, input logic sp, input logic cl,
                       input logic [3:0] em, input logic [3:0] et, input logic [3:0] eo,
                       input logic er, input logic ez, input logic ed);
        vec_t v;
        v.rst = r;  v.tick = t; v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.cl = cl;
        v.em  = em; v.et = et;  v.eo = eo; v.er = er; v.ez = ez; v.ed = ed;
        vecs.push_back(v);
    endtask

    // Packed view {min, tens, ones, running, zero, done} for compact reporting.
    function automatic logic [14:0] pack(input logic [3:0] m, input logic [3:0] t,
                                         input logic [3:0] o, input logic r,
                                         input logic z, input logic d);
        return {m, t, o, r, z, d};
    endfunction

    task automatic check(input string name, input logic [14:0] exp_v);
        logic [14:0] act;
        act = pack(min_w, tens_w, ones_w, running_w, zero_w, done_w);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h:%0h%0h run=%b zero=%b done=%b, want %0h:%0h%0h run=%b zero=%b done=%b",
                     name, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                     exp_v[14:11], exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; tick_1hz = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef DOOR_INTERLOCK_EN
        door_open = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        idle_inputs();
        key_valid = 1'b1; key_digit = d;
        step();
        idle_inputs();
    endtask

    initial begin
        int rem;
        idle_inputs();
        rst = 1'b1;

        // rst t kv kd st sp cl | min tens ones run zero done
        add(1,0,0, 0,0,0,0, 0,0,0, 0,1,0);   // reset state
        add(0,0,1, 1,0,0,0, 0,0,1, 0,0,0);   // keys 1,3,0
        add(0,0,1, 3,0,0,0, 0,1,3, 0,0,0);
        add(0,0,1, 0,0,0,0, 1,3,0, 0,0,0);
        add(0,0,0, 0,1,0,0, 1,3,0, 1,0,0);   // start
        add(0,1,0, 0,0,0,0, 1,2,9, 1,0,0);   // borrow from sec_tens
        add(0,0,0, 0,0,0,0, 1,2,9, 1,0,0);   // no tick: hold
        add(0,1,0, 0,0,0,0, 1,2,8, 1,0,0);
        add(0,1,0, 0,0,0,0, 1,2,7, 1,0,0);   // 1:27 running
        add(0,0,0, 0,0,0,1, 0,0,0, 0,1,0);   // clear while running
        add(0,0,0, 0,1,0,0, 0,0,0, 0,1,0);   // start at 0:00 ignored
        add(0,0,1, 1,0,0,0, 0,0,1, 0,0,0);   // load 1:00
        add(0,0,1, 0,0,0,0, 0,1,0, 0,0,0);
        add(0,0,1, 0,0,0,0, 1,0,0, 0,0,0);
        add(0,0,0, 0,1,0,0, 1,0,0, 1,0,0);
        add(0,1,0, 0,0,0,0, 0,5,9, 1,0,0);   // full borrow chain -> 0:59
        add(0,0,0, 0,0,0,1, 0,0,0, 0,1,0);
        add(0,0,1, 7,0,0,0, 0,0,7, 0,0,0);   // key 7
        add(0,0,1, 2,0,0,0, 0,0,7, 0,0,0);   // key 2 rejected (tens would be 7)
        add(0,0,1,12,0,0,0, 0,0,7, 0,0,0);   // non-BCD key ignored
        add(0,0,0, 0,1,0,0, 0,0,7, 1,0,0);
        add(0,0,1, 5,0,0,0, 0,0,7, 1,0,0);   // key ignored while running
        add(1,0,0, 0,0,0,0, 0,0,0, 0,1,0);   // reset while running
        add(0,0,1, 2,0,0,0, 0,0,2, 0,0,0);   // load 2:15
        add(0,0,1, 1,0,0,0, 0,2,1, 0,0,0);
        add(0,0,1, 5,0,0,0, 2,1,5, 0,0,0);
        add(0,0,0, 0,1,0,0, 2,1,5, 1,0,0);
        add(0,1,0, 0,0,1,0, 2,1,5, 0,0,0);   // stop beats tick -> paused
        add(0,1,0, 0,0,0,0, 2,1,5, 0,0,0);   // tick while paused has no effect
        add(0,0,0, 0,1,0,0, 2,1,5, 1,0,0);   // resume
        add(0,1,0, 0,0,0,0, 2,1,4, 1,0,0);
        add(1,0,0, 0,0,0,0, 0,0,0, 0,1,0);
        add(0,0,1, 4,0,0,0, 0,0,4, 0,0,0);   // load 4:33
        add(0,0,1, 3,0,0,0, 0,4,3, 0,0,0);
        add(0,0,1, 3,0,0,0, 4,3,3, 0,0,0);
        add(0,0,0, 0,1,0,0, 4,3,3, 1,0,0);
        add(1,1,0, 0,0,0,0, 0,0,0, 0,1,0);   // reset overrides tick mid-count
        add(0,0,1, 1,0,0,0, 0,0,1, 0,0,0);   // load 0:01
        add(0,0,0, 0,1,0,0, 0,0,1, 1,0,0);
        add(0,1,0, 0,0,0,0, 0,0,0, 0,1,1);   // reaches 0:00 -> DONE, pulse
        add(0,0,0, 0,0,0,0, 0,0,0, 0,1,0);   // pulse lasts one cycle
        add(0,0,0, 0,1,0,0, 0,0,0, 0,1,0);   // start ignored in DONE
        add(0,0,1, 5,0,0,0, 0,0,0, 0,1,0);   // key ignored in DONE
        add(0,0,0, 0,0,0,1, 0,0,0, 0,1,0);   // clear -> IDLE
        add(0,0,1, 5,0,0,0, 0,0,5, 0,0,0);   // keys accepted again
        add(0,0,0, 0,1,0,1, 0,0,0, 0,1,0);   // clear beats start
        add(0,0,1, 5,0,0,0, 0,0,5, 0,0,0);
        add(0,0,0, 0,1,1,0, 0,0,5, 1,0,0);   // stop has no effect in IDLE
        add(0,0,1, 3,1,0,0, 0,0,5, 1,0,0);   // start+key while running: no change

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            tick_1hz  = vecs[i].tick;
            key_valid = vecs[i].kv;
            key_digit = vecs[i].kd;
            start     = vecs[i].st;
            stop      = vecs[i].sp;
            clear     = vecs[i].cl;
            step();
            check($sformatf("vec%0d", i),
                  pack(vecs[i].em, vecs[i].et, vecs[i].eo, vecs[i].er, vecs[i].ez, vecs[i].ed));
        end

        // Full countdown from 1:05 against a plain seconds model.
        idle_inputs();
        rst = 1'b1;
        step();
        idle_inputs();
        press(4'd1);
        press(4'd0);
        press(4'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        rem = 65;
        check("load_1_05", pack(4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0));
        while (rem > 0) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            rem--;
            check($sformatf("count_%0d", rem),
                  pack(4'(rem / 60), 4'((rem % 60) / 10), 4'(rem % 10),
                       rem != 0, rem == 0, rem == 0));
            step();   // one idle cycle between ticks
        end
        for (int k = 0; k < 3; k++) begin
            tick_1hz = 1'b1;
            step();
            check($sformatf("after_done_%0d", k), pack(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
        end
        idle_inputs();

`ifdef DOOR_INTERLOCK_EN
        clear = 1'b1;
        step();
        idle_inputs();
        press(4'd2);
        start = 1'b1;
        step();
        idle_inputs();
        check("door_run", pack(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0));
        door_open = 1'b1; tick_1hz = 1'b1;
        step();
        check("door_pause", pack(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0));
        tick_1hz = 1'b0; start = 1'b1;
        step();
        check("door_blocks_start", pack(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0));
        door_open = 1'b0;
        step();
        check("door_closed_start", pack(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0));
        idle_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_countdown_timer
`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: MAX_MIN, default 9, largest minutes value accepted from keypad entry (1..9).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 tick_1hz  input  1  one-clk-wide enable pulse, once per second.
REQ-005 key_valid  input  1  one-clk-wide strobe: key_digit holds a new keypad digit.
REQ-006 key_digit  input  4  BCD digit entered from the keypad.
REQ-007 start  input  1  level-sampled start request.
REQ-008 stop  input  1  level-sampled pause request.
REQ-009 clear  input  1  level-sampled clear request.
REQ-010 min, sec_tens, sec_ones  output  4 each  BCD time digits; they feed the 7-segment decoder directly.
REQ-011 running  output  1  high while in RUNNING.
REQ-012 zero  output  1  high when all three digits equal 0.
REQ-013 done_pulse  output  1  one-clk pulse when the countdown reaches 0:00.

Function
REQ-014 The FSM SHALL have states IDLE, RUNNING, PAUSED and DONE.
REQ-015 Digit ranges: min 0..MAX_MIN, sec_tens 0..5, sec_ones 0..9; no output SHALL ever leave its range.
REQ-016 In IDLE, key_valid with key_digit<=9 SHALL shift digits left in one cycle: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
REQ-017 Keys SHALL be ignored in whole if key_digit>9, if the shift would make sec_tens>5 or min>MAX_MIN, or if the state is not IDLE.
REQ-018 start in IDLE or PAUSED with zero=0 SHALL enter RUNNING next cycle; start with zero=1 SHALL be ignored.
REQ-019 In RUNNING, each tick_1hz SHALL decrement the time by one second in the same edge.
  - sec_ones 0->9 with borrow; sec_tens 0->5 with borrow; min decrements on borrow.
REQ-020 A decrement that yields 0:00 SHALL move to DONE and assert done_pulse for exactly one cycle on that edge.
REQ-021 stop in RUNNING SHALL enter PAUSED and hold the digits; stop in any other state has no effect.
REQ-022 clear in any state SHALL zero all digits and enter IDLE next cycle.
REQ-023 DONE SHALL hold 0:00 and leave only on clear (to IDLE); start and keys are ignored.
REQ-024 Same-cycle priority SHALL be clear > stop > start > tick_1hz > key_valid; a suppressed tick is lost, not deferred.
REQ-025 running and zero SHALL be registered-state decodes with no added latency.

Reset
REQ-026 rst SHALL force IDLE and min=sec_tens=sec_ones=0, giving running=0, zero=1 and done_pulse=0; it overrides all other inputs, including mid-count.

Configuration
REQ-027 When DOOR_INTERLOCK_EN is defined, a 1-bit input door_open SHALL exist.
  - door_open=1 in RUNNING forces PAUSED next cycle, with priority just below clear.
  - start is ignored while door_open=1.
REQ-028 When DOOR_INTERLOCK_EN is undefined, door_open SHALL be absent and the behaviour SHALL be exactly REQ-014..REQ-026.

Structure
REQ-029 Package timer_pkg SHALL hold the state enumeration, the BCD limits (9, 5) and the zero-digit constant.
REQ-030 Sub-module bcd_digit_down (parameter: digit max; ports: digit in, decrement enable, digit out, borrow out) SHALL be instantiated once per digit.

Verification
REQ-031 Keys 1,3,0 then start; 3 ticks -> digits 1:27, running=1.
REQ-032 Load 1:00, start, 1 tick -> 0:59 (borrow chain across both seconds digits).
REQ-033 Load 0:01, start, 1 tick -> 0:00, DONE state, done_pulse high exactly 1 cycle; a following start is ignored.
REQ-034 Keys 7 then 2 -> second key rejected (sec_tens would be 7); digits stay 0:07.
REQ-035 RUNNING at 2:15 with stop and tick in the same cycle -> PAUSED at 2:15; start then 1 tick -> 2:14.
REQ-036 rst mid-count at 4:33 -> 0:00, IDLE, zero=1 next cycle; with DOOR_INTERLOCK_EN, door_open=1 while RUNNING -> PAUSED.
